app_result_tx: RTL and testbench

//  - Serial transmitter sending APP result words (adder c_o path) off-chip on one output pad.
//  - Replaces the parallel c pads; the bench/FPGA receiver is the far end.
//  - Sits between the core result register and a PDDW0408SCDG output pad (OEN=0, IE=0).
//  - UART-style frame: start bit, LSB-first data, optional parity, stop bit.

---
 rtl/app_result_tx.sv | 171 +++++++++++++++++
 tb/tb_app_result_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/app_result_tx.sv
// Serial UART-style transmitter for APP result words (adder c_o path) to one output pad.
// Latency: tx_o drops to the start bit 1 clk after accept; frame = (DATA_W+2[+1])*(div+1) clk.
// Backpressure: ready_o is high only in IDLE; valid_i while busy is ignored, nothing is queued.
//
// Ports:
//   clk      in   core clock
//   rst      in   asynchronous active-high reset (async assert, sync release upstream)
//   data_i   in   [DATA_W-1:0] word to transmit, latched on accept
//   valid_i  in   word available
//   ready_o  out  block can accept (IDLE only)
//   div_i    in   [DIV_W-1:0] bit period minus 1 in clk cycles, latched on accept
//   tx_o     out  serial line, registered, idles high
//   busy_o   out  frame in progress
//   done_o   out  one-cycle pulse in the last cycle of the stop bit
//
// Build option: define APP_TX_PARITY_EN to insert an even-parity bit between the
// last data bit and the stop bit. The port list is the same in both builds.

module app_result_tx #(
    parameter int DATA_W = 5,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DIV_W-1:0]  div_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef APP_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_q;
    logic              tx_q;
`ifdef APP_TX_PARITY_EN
    logic              parity_q;
`endif

    logic              bit_end;
    logic              accept;
    logic [DATA_W-1:0] sh_next;

    // The divider counter is cleared at every bit boundary, so a plain equality
    // compare marks the last cycle of each bit without any wrap concern.
    assign bit_end = (div_cnt == div_q);
    assign accept  = valid_i && (state == ST_IDLE);
    assign sh_next = shreg >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            div_q    <= '0;
            tx_q     <= 1'b1;
`ifdef APP_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        // Word and rate are captured here; later changes on
                        // data_i/div_i cannot disturb the frame in flight.
                        state    <= ST_START;
                        shreg    <= data_i;
                        div_q    <= div_i;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
`ifdef APP_TX_PARITY_EN
                        parity_q <= ^data_i;
`endif
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        div_cnt <= '0;
                        tx_q    <= shreg[0];
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef APP_TX_PARITY_EN
                            state   <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state   <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // Shift first and drive the new LSB so tx_q
                            // changes on the same edge as the bit boundary.
                            bit_cnt <= bit_cnt + CNT_ONE;
                            shreg   <= sh_next;
                            tx_q    <= sh_next[0];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end

`ifdef APP_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        div_cnt <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
`endif

                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        // Always pass through IDLE for one cycle: that cycle is
                        // the guaranteed extra high time before the next start.
                        state   <= ST_IDLE;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = (state == ST_IDLE);
    assign busy_o  = (state != ST_IDLE);
    assign done_o  = (state == ST_STOP) && bit_end;

endmodule

// File: tb/tb_app_result_tx.sv
// Testbench for app_result_tx: per-cycle expected line/handshake values are queued
// when a word is offered and popped against the DUT on each falling clock edge.
// Works in both builds; the parity scenario runs only with APP_TX_PARITY_EN.

module tb_app_result_tx;

    localparam int DATA_W = 5;
    localparam int DIV_W  = 8;
`ifdef APP_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 3;
`else
    localparam int FRAME_BITS = DATA_W + 2;
`endif

    typedef struct packed {
        logic tx;
        logic done;
        logic ready;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic [DIV_W-1:0]  div_i;
    logic              tx_o;
    logic              busy_o;
    logic              done_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    app_result_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .div_i   (div_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    // Reference frame: start, LSB-first data, optional even parity, stop;
    // every bit repeated div+1 cycles, done only in the very last cycle.
    task automatic push_frame(input logic [DATA_W-1:0] d, input int dv);
        logic v;
        exp_t e;
        for (int b = 0; b < FRAME_BITS; b++) begin
            if (b == 0)
                v = 1'b0;
            else if (b <= DATA_W)
                v = d[b-1];
            else if (b == FRAME_BITS - 1)
                v = 1'b1;
            else
                v = ^d;
            for (int c = 0; c <= dv; c++) begin
                e.tx    = v;
                e.done  = (b == FRAME_BITS - 1) && (c == dv);
                e.ready = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e.tx = 1'b1; e.done = 1'b0; e.ready = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_i = 1'b0; data_i = '0; div_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_o, done_o, ready_o, busy_o} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_hold tx/done/ready/busy got %b exp 1010", {tx_o, done_o, ready_o, busy_o});
        end
        rst = 1'b0;
        @(negedge clk);
        valid_i = 1'b1; data_i = 5'b00000; div_i = 8'd3;
        @(negedge clk);
        valid_i = 1'b0;
        // 4 START cycles, this negedge is START cycle 1; advance to DATA bit0
        repeat (4) @(negedge clk);
        checks++;
        if ({tx_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL reset_middata tx/busy got %b exp 01", {tx_o, busy_o});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({tx_o, done_o, ready_o, busy_o} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_async tx/done/ready/busy got %b exp 1010", {tx_o, done_o, ready_o, busy_o});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_o, done_o, ready_o, busy_o} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_release tx/done/ready/busy got %b exp 1010", {tx_o, done_o, ready_o, busy_o});
        end
    endtask

    task automatic test_single;
        exp_t e;
        exp_q.delete();
        @(negedge clk);
        valid_i = 1'b1; data_i = 5'b10110; div_i = 8'd0;
        push_frame(5'b10110, 0);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({tx_o, done_o, ready_o, busy_o} !== {e.tx, e.done, e.ready, ~e.ready}) begin
                errors++;
                $display("FAIL single cyc %0d tx/done/ready/busy got %b exp %b", i + 1,
                         {tx_o, done_o, ready_o, busy_o}, {e.tx, e.done, e.ready, ~e.ready});
            end
            if (i == 0) valid_i = 1'b0;
        end
    endtask

    task automatic test_slow;
        exp_t e;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({tx_o, ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL slow_pre tx/ready got %b exp 11", {tx_o, ready_o});
        end
        valid_i = 1'b1; data_i = 5'b00001; div_i = 8'd3;
        push_frame(5'b00001, 3);
        push_idle(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({tx_o, done_o, ready_o, busy_o} !== {e.tx, e.done, e.ready, ~e.ready}) begin
                errors++;
                $display("FAIL slow cyc %0d tx/done/ready/busy got %b exp %b", i + 1,
                         {tx_o, done_o, ready_o, busy_o}, {e.tx, e.done, e.ready, ~e.ready});
            end
            if (i == 0) valid_i = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int second_start;
        exp_q.delete();
        second_start = FRAME_BITS * 2 + 1;
        @(negedge clk);
        valid_i = 1'b1; data_i = 5'h1F; div_i = 8'd1;
        push_frame(5'h1F, 1);
        push_idle(1);
        push_frame(5'h00, 1);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({tx_o, done_o, ready_o, busy_o} !== {e.tx, e.done, e.ready, ~e.ready}) begin
                errors++;
                $display("FAIL b2b cyc %0d tx/done/ready/busy got %b exp %b", i + 1,
                         {tx_o, done_o, ready_o, busy_o}, {e.tx, e.done, e.ready, ~e.ready});
            end
            // Next word presented mid-frame with valid held; must not leak into frame 1.
            if (i == 0) data_i = 5'h00;
            if (i == second_start) valid_i = 1'b0;
        end
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        exp_q.delete();
        @(negedge clk);
        valid_i = 1'b1; data_i = 5'b10011; div_i = 8'd0;
        push_frame(5'b10011, 0);
        push_idle(3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({tx_o, done_o, ready_o, busy_o} !== {e.tx, e.done, e.ready, ~e.ready}) begin
                errors++;
                $display("FAIL busy_ignore cyc %0d tx/done/ready/busy got %b exp %b", i + 1,
                         {tx_o, done_o, ready_o, busy_o}, {e.tx, e.done, e.ready, ~e.ready});
            end
            if (i == 0) valid_i = 1'b0;
            if (i == 2) begin valid_i = 1'b1; data_i = 5'h0A; end
            if (i == 3) valid_i = 1'b0;
        end
    endtask

`ifdef APP_TX_PARITY_EN
    task automatic test_parity;
        exp_t e;
        exp_q.delete();
        @(negedge clk);
        valid_i = 1'b1; data_i = 5'b00111; div_i = 8'd0;
        push_frame(5'b00111, 0);
        push_idle(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({tx_o, done_o, ready_o, busy_o} !== {e.tx, e.done, e.ready, ~e.ready}) begin
                errors++;
                $display("FAIL parity cyc %0d tx/done/ready/busy got %b exp %b", i + 1,
                         {tx_o, done_o, ready_o, busy_o}, {e.tx, e.done, e.ready, ~e.ready});
            end
            if (i == 0) valid_i = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_slow();
        test_back_to_back();
        test_busy_ignore();
`ifdef APP_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
